// File: rtl/hk_const_mem.sv
// SHA-256 H/K constant store: copies the FIPS 180-4 constant ROM into a
// 128x32 RAM after reset, then serves registered reads from the H or K bank.
module hk_const_mem #(
  parameter int H_WORDS = 8,
  parameter int K_WORDS = 64,
  parameter int K_BASE  = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        HK_SELECTOR,
  input  logic [2:0]  H_ADDR,
  input  logic [5:0]  K_ADDR,
  output logic [31:0] RAM_DR,
  output logic        RDY
);

  localparam logic [0:0] S_COPY  = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  localparam logic [6:0] LAST   = 7'(H_WORDS + K_WORDS - 1);
  localparam logic [6:0] HW     = 7'(H_WORDS);
  localparam logic [6:0] K_OFS  = 7'(K_BASE - H_WORDS);
  localparam logic [6:0] K_BASE_A = 7'(K_BASE);

  logic [31:0] ram [128];
  logic [0:0]  state;
  logic [6:0]  ctr;
  logic [6:0]  waddr;
  logic [6:0]  raddr;
  logic        we;
  logic [31:0] rom_q;

  function automatic logic [31:0] rom(input logic [6:0] i);
    logic [31:0] v;
    v = '0;
    unique case (i)
      7'd0:  v = 32'h6a09e667;
      7'd1:  v = 32'hbb67ae85;
      7'd2:  v = 32'h3c6ef372;
      7'd3:  v = 32'ha54ff53a;
      7'd4:  v = 32'h510e527f;
      7'd5:  v = 32'h9b05688c;
      7'd6:  v = 32'h1f83d9ab;
      7'd7:  v = 32'h5be0cd19;
      7'd8:  v = 32'h428a2f98;
      7'd9:  v = 32'h71374491;
      7'd10: v = 32'hb5c0fbcf;
      7'd11: v = 32'he9b5dba5;
      7'd12: v = 32'h3956c25b;
      7'd13: v = 32'h59f111f1;
      7'd14: v = 32'h923f82a4;
      7'd15: v = 32'hab1c5ed5;
      7'd16: v = 32'hd807aa98;
      7'd17: v = 32'h12835b01;
      7'd18: v = 32'h243185be;
      7'd19: v = 32'h550c7dc3;
      7'd20: v = 32'h72be5d74;
      7'd21: v = 32'h80deb1fe;
      7'd22: v = 32'h9bdc06a7;
      7'd23: v = 32'hc19bf174;
      7'd24: v = 32'he49b69c1;
      7'd25: v = 32'hefbe4786;
      7'd26: v = 32'h0fc19dc6;
      7'd27: v = 32'h240ca1cc;
      7'd28: v = 32'h2de92c6f;
      7'd29: v = 32'h4a7484aa;
      7'd30: v = 32'h5cb0a9dc;
      7'd31: v = 32'h76f988da;
      7'd32: v = 32'h983e5152;
      7'd33: v = 32'ha831c66d;
      7'd34: v = 32'hb00327c8;
      7'd35: v = 32'hbf597fc7;
      7'd36: v = 32'hc6e00bf3;
      7'd37: v = 32'hd5a79147;
      7'd38: v = 32'h06ca6351;
      7'd39: v = 32'h14292967;
      7'd40: v = 32'h27b70a85;
      7'd41: v = 32'h2e1b2138;
      7'd42: v = 32'h4d2c6dfc;
      7'd43: v = 32'h53380d13;
      7'd44: v = 32'h650a7354;
      7'd45: v = 32'h766a0abb;
      7'd46: v = 32'h81c2c92e;
      7'd47: v = 32'h92722c85;
      7'd48: v = 32'ha2bfe8a1;
      7'd49: v = 32'ha81a664b;
      7'd50: v = 32'hc24b8b70;
      7'd51: v = 32'hc76c51a3;
      7'd52: v = 32'hd192e819;
      7'd53: v = 32'hd6990624;
      7'd54: v = 32'hf40e3585;
      7'd55: v = 32'h106aa070;
      7'd56: v = 32'h19a4c116;
      7'd57: v = 32'h1e376c08;
      7'd58: v = 32'h2748774c;
      7'd59: v = 32'h34b0bcb5;
      7'd60: v = 32'h391c0cb3;
      7'd61: v = 32'h4ed8aa4a;
      7'd62: v = 32'h5b9cca4f;
      7'd63: v = 32'h682e6ff3;
      7'd64: v = 32'h748f82ee;
      7'd65: v = 32'h78a5636f;
      7'd66: v = 32'h84c87814;
      7'd67: v = 32'h8cc70208;
      7'd68: v = 32'h90befffa;
      7'd69: v = 32'ha4506ceb;
      7'd70: v = 32'hbef9a3f7;
      7'd71: v = 32'hc67178f2;
      default: v = '0;
    endcase
    return v;
  endfunction

  // K words land above the unused hole at RAM 8..K_BASE-1
  always_comb begin
    rom_q = rom(ctr);
    waddr = (ctr < HW) ? ctr : ctr + K_OFS;
    raddr = HK_SELECTOR ? K_BASE_A + {1'b0, K_ADDR}
                        : {4'b0, H_ADDR};
    we    = (state == S_COPY);
  end

  // RAM has no reset so its contents survive RST
  always_ff @(posedge CLK) begin
    if (we) ram[waddr] <= rom_q;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= S_COPY;
      ctr    <= '0;
      RDY    <= 1'b0;
      RAM_DR <= '0;
    end else begin
      unique case (state)
        S_COPY: begin
          RAM_DR <= '0;
          ctr    <= ctr + 7'd1;
          if (ctr == LAST) begin
            state <= S_READY;
            RDY   <= 1'b1;
          end
        end
        S_READY: begin
          RAM_DR <= ram[raddr];
        end
        default: begin
          state <= S_COPY;
          ctr   <= '0;
          RDY   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hk_const_mem.sv
// Directed bench for hk_const_mem: copy timing, H/K reads, bank toggling
// and reset during copy and during READY.
module tb_hk_const_mem;

  logic        CLK;
  logic        RST;
  logic        HK_SELECTOR;
  logic [2:0]  H_ADDR;
  logic [5:0]  K_ADDR;
  logic [31:0] RAM_DR;
  logic        RDY;

  int n_vec;
  int n_bad;

  logic [31:0] h_tab [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  logic [31:0] k_tab [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  hk_const_mem dut (
    .CLK         (CLK),
    .RST         (RST),
    .HK_SELECTOR (HK_SELECTOR),
    .H_ADDR      (H_ADDR),
    .K_ADDR      (K_ADDR),
    .RAM_DR      (RAM_DR),
    .RDY         (RDY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // release reset just after an edge and walk the 72 copy edges
  task automatic copy_run(input string tag, input bit scramble);
    RST = 1'b1;
    for (int e = 1; e <= 72; e++) begin
      if (scramble) begin
        HK_SELECTOR = 1'($urandom_range(0, 1));
        H_ADDR      = 3'($urandom_range(0, 7));
        K_ADDR      = 6'($urandom_range(0, 63));
      end
      tick();
      check($sformatf("%s_rdy_e%0d", tag, e), {31'b0, RDY},
            {31'b0, e == 72});
      check($sformatf("%s_dr_e%0d", tag, e), RAM_DR, 32'h0);
    end
  endtask

  task automatic read_h(input string tag, input int i);
    HK_SELECTOR = 1'b0;
    H_ADDR      = 3'(i);
    tick();
    check($sformatf("%s_h%0d", tag, i), RAM_DR, h_tab[i]);
  endtask

  task automatic read_k(input string tag, input int i);
    HK_SELECTOR = 1'b1;
    K_ADDR      = 6'(i);
    tick();
    check($sformatf("%s_k%0d", tag, i), RAM_DR, k_tab[i]);
  endtask

  initial begin
    n_vec       = 0;
    n_bad       = 0;
    RST         = 1'b0;
    HK_SELECTOR = 1'b0;
    H_ADDR      = '0;
    K_ADDR      = '0;

    tick();
    tick();
    check("reset_rdy", {31'b0, RDY}, 32'h0);
    check("reset_dr", RAM_DR, 32'h0);

    copy_run("copy1", 1'b0);

    for (int i = 0; i < 8; i++) read_h("rd1", i);
    read_k("rd1", 0);
    read_k("rd1", 1);
    read_k("rd1", 62);
    read_k("rd1", 63);

    H_ADDR = 3'd7;
    K_ADDR = 6'd0;
    for (int c = 0; c < 8; c++) begin
      HK_SELECTOR = 1'(c % 2);
      tick();
      check($sformatf("toggle_%0d", c), RAM_DR,
            (c % 2) ? 32'h428a2f98 : 32'h5be0cd19);
    end

    // reset at copy edge 30
    HK_SELECTOR = 1'b0;
    RST = 1'b0;
    tick();
    RST = 1'b1;
    for (int e = 1; e <= 30; e++) tick();
    RST = 1'b0;
    #1;
    check("midcopy_rdy", {31'b0, RDY}, 32'h0);
    check("midcopy_dr", RAM_DR, 32'h0);
    tick();
    copy_run("copy2", 1'b1);
    for (int i = 0; i < 8; i++) read_h("rd2", i);
    for (int i = 0; i < 64; i++) read_k("rd2", i);

    // reset while READY with nonzero output
    read_h("pre_rst", 0);
    RST = 1'b0;
    #1;
    check("ready_rst_rdy", {31'b0, RDY}, 32'h0);
    check("ready_rst_dr", RAM_DR, 32'h0);
    tick();
    copy_run("copy3", 1'b0);
    read_h("rd3", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hk_const_mem.md
HK_CONST_MEM -- requirements
Module: hk_const_mem

Interface
REQ-001 The module SHALL have parameter H_WORDS, default 8, giving the number of SHA-256 initial hash words.
REQ-002 The module SHALL have parameter K_WORDS, default 64, giving the number of SHA-256 round constants.
REQ-003 The module SHALL have parameter K_BASE, default 64, giving the RAM word address of K[0].
REQ-004 CLK  input  1  sole clock; all state changes on the rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-low; 0 = in reset.
REQ-006 HK_SELECTOR  input  1  read-bank select; 0 = H bank, 1 = K bank.
REQ-007 H_ADDR  input  3  H word index 0..7.
REQ-008 K_ADDR  input  6  K word index 0..63.
REQ-009 RAM_DR  output  32  registered read data.
REQ-010 RDY  output  1  high when the copy is complete and reads are valid.

Function
REQ-011 The block SHALL contain a 72x32 constant ROM: index 0..7 = H0..H7, index 8..71 = K0..K63, all per FIPS 180-4.
REQ-012 ROM values SHALL include H0=6a09e667, H7=5be0cd19, K0=428a2f98, K1=71374491, K63=c67178f2.
REQ-013 The block SHALL contain a 128x32 RAM; RAM words are written only by the internal copy engine, with no external write port.
REQ-014 The block SHALL have a copy engine with a 7-bit counter CTR and two states: COPY and READY.
REQ-015 In COPY, each rising edge SHALL write ROM[CTR] into RAM[map(CTR)] and then increment CTR.
REQ-016 The address map SHALL be map(i) = i for i < 8 and map(i) = i + 56 for i >= 8, so ROM 8..71 maps to RAM 64..127.
REQ-017 The write of ROM[71] SHALL move the FSM to READY and set RDY=1 on the same edge; total copy time is 72 rising edges after reset release.
REQ-018 In READY, the FSM SHALL stay in READY, CTR SHALL hold, and no further RAM writes SHALL occur.
REQ-019 The read address SHALL be {5'b0, H_ADDR} when HK_SELECTOR=0 and {2'b01, K_ADDR} when HK_SELECTOR=1.
REQ-020 In READY, each rising edge SHALL load RAM_DR with RAM[read address], giving a latency of 1 clock from address/select change to data.
REQ-021 In COPY, RAM_DR SHALL be held at 32'h0, and H_ADDR, K_ADDR and HK_SELECTOR SHALL be ignored.
REQ-022 RAM locations 8..63 SHALL never be written and SHALL never be readable through the address map.
REQ-023 RDY SHALL go high in the same cycle as the last copy write; the first valid RAM_DR SHALL appear one edge after RDY rises.
REQ-024 Inputs SHALL be allowed to change every cycle in READY; RAM_DR SHALL always follow the address sampled on the previous edge, with no stalls.

Reset
REQ-025 RST=0 SHALL immediately (asynchronously) force FSM=COPY, CTR=0, RDY=0 and RAM_DR=0.
REQ-026 RAM contents SHALL NOT be cleared by reset.
REQ-027 Reset SHALL be released synchronously, and copying SHALL start on the first rising edge with RST=1.
REQ-028 Reset asserted mid-copy or in READY SHALL abort the current state, and the copy SHALL restart from CTR=0 after release.
REQ-029 After a mid-copy reset, all 72 words SHALL be rewritten and RDY SHALL rise exactly 72 edges after the new release.

Verification
REQ-030 Scenario: release RST, hold HK_SELECTOR=0 -> RDY=0 for edges 1..71, RDY=1 after edge 72, RAM_DR=0 throughout the copy.
REQ-031 Scenario: after RDY, HK_SELECTOR=0, H_ADDR=0..7 -> RAM_DR = 6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19, each one edge later.
REQ-032 Scenario: HK_SELECTOR=1, K_ADDR = 0, 1, 62, 63 -> RAM_DR = 428a2f98, 71374491, bef9a3f7, c67178f2.
REQ-033 Scenario: toggle HK_SELECTOR every cycle with H_ADDR=7, K_ADDR=0 -> RAM_DR alternates 5be0cd19 / 428a2f98 with 1-cycle lag.
REQ-034 Scenario: assert RST=0 at copy edge 30 -> RDY and RAM_DR drop immediately; after release, RDY rises at edge 72 and all 72 words read back correctly.
REQ-035 Scenario: assert RST=0 in READY -> RDY=0 at once; after release, RDY returns after 72 edges and H0 reads 6a09e667.
